uart_echo_fifo: RTL and testbench

Parametrised byte-echo engine between `uart_rx` and `uart_tx`. Buffers every received character in a circular FIFO, optionally XORs it with a mask (the case-toggle echo when the mask is 0x20), and replays the buffered characters through a send/busy handshake. Received bytes are never lost while the FIFO has space. Also provides a sticky overflow flag and a one-second heartbeat. Instantiated in the top level in place of ad-hoc echo glue.

---
 rtl/uart_echo_fifo.sv | 179 +++++++++++++++++
 tb/tb_uart_echo_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffers uart_rx bytes in a circular FIFO (optional XOR mask at push) and replays them to uart_tx.
// Latency: rx_ready rise in cycle N -> tx_send/tx_data in cycle N+2 with an empty FIFO and idle transmitter.
// Backpressure: tx_busy stalls replay via send/busy handshake; pushes into a full FIFO are dropped and set sticky overflow.
// Optional build: define UART_ECHO_FIFO_STATS_EN to add 16-bit rx_count/tx_count outputs.
module uart_echo_fifo #(
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] XOR_MASK = DATA_W'('h20),
    parameter int                CLKFREQ  = 12000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef UART_ECHO_FIFO_STATS_EN
    output logic [15:0]              rx_count,
    output logic [15:0]              tx_count,
`endif
    input  logic                     rx_ready,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     xor_en,
    input  logic                     tx_busy,
    output logic                     tx_send,
    output logic [DATA_W-1:0]        tx_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     heartbeat
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int HB_W  = (CLKFREQ > 1) ? $clog2(CLKFREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic              rx_ready_q;
    logic              armed;
    logic              push_evt;
    logic              push_ok;
    logic              drop;
    logic              pop;
    logic              full;
    logic              empty;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [HB_W-1:0]   hb_cnt;

    // armed stays low for the first cycle after reset so a level already high
    // at release is absorbed into rx_ready_q instead of being seen as an edge.
    assign push_evt = rx_ready & ~rx_ready_q & armed;
    assign full     = (fifo_level == LVL_W'(DEPTH));
    assign empty    = (fifo_level == '0);
    // Pop only on the IDLE->REQ transition; an empty FIFO never pops (no bypass).
    assign pop      = (state == S_IDLE) && !empty && !tx_busy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push_evt && (!full || pop);
    assign drop     = push_evt && full && !pop;

    // Edge-detect history and post-reset arming.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q <= 1'b0;
            armed      <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            armed      <= 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data ^ (xor_en ? XOR_MASK : '0);
        end
    end

    // Circular pointers (power-of-two depth wraps naturally) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Transmit handshake FSM with registered tx_send/tx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        tx_data <= mem[rd_ptr];
                        tx_send <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // No timeout: a transmitter that never goes busy holds us here.
                    if (tx_busy) begin
                        tx_send <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running heartbeat divider; toggles the output on each wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == HB_W'(CLKFREQ - 1)) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
        end
    end

`ifdef UART_ECHO_FIFO_STATS_EN
    // Traffic counters: every edge counts as received (dropped bytes included), every pop as sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (push_evt) begin
                rx_count <= rx_count + 16'd1;
            end
            if (pop) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: directed + randomized checks of uart_echo_fifo against a queue-based model.
// Latency: checks N+2 echo latency, 2-cycle back-to-back gap and registered level timing.
// Backpressure: bench plays the uart_tx side, holding tx_busy for random durations.
module tb_uart_echo_fifo;

    localparam int         DEPTH = 16;
    localparam logic [7:0] MASK  = 8'h20;

    logic       clk;
    logic       rst_n;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       xor_en;
    logic       tx_busy;
    logic       tx_send;
    logic [7:0] tx_data;
    logic [4:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;
    logic       heartbeat;
`ifdef UART_ECHO_FIFO_STATS_EN
    logic [15:0] rx_count;
    logic [15:0] tx_count;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    bit         exp_ovf = 1'b0;

    uart_echo_fifo #(
        .DATA_W  (8),
        .DEPTH   (DEPTH),
        .XOR_MASK(MASK),
        .CLKFREQ (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef UART_ECHO_FIFO_STATS_EN
        .rx_count  (rx_count),
        .tx_count  (tx_count),
`endif
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .xor_en    (xor_en),
        .tx_busy   (tx_busy),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .heartbeat (heartbeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // One rx_ready pulse while no pop can happen (tx_busy held high by the caller).
    task automatic push(input logic [7:0] d, input bit xe, input bit clr);
        rx_data  = d;
        xor_en   = xe;
        rx_ready = 1'b1;
        ovf_clr  = clr;
        tick();
        rx_ready = 1'b0;
        ovf_clr  = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(d ^ (xe ? MASK : 8'h00));
        else                      exp_ovf = 1'b1;
        if (clr && exp_q.size() < DEPTH) exp_ovf = 1'b0;
        tick();
    endtask

    // Behave as uart_tx for n bytes: accept each send, go busy, then idle again.
    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            int         cnt;
            int         hold;
            logic [7:0] want;
            cnt = 0;
            while (tx_send !== 1'b1 && cnt < 40) begin
                tick();
                cnt++;
            end
            check("send_seen", {31'd0, tx_send}, 32'd1);
            if (i > 0) check("b2b_gap", cnt, 2);
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("tx_order", {24'd0, tx_data}, {24'd0, want});
            tx_busy = 1'b1;
            tick();
            check("send_drop", {31'd0, tx_send}, 32'd0);
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            check("data_stable", {24'd0, tx_data}, {24'd0, want});
            tx_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_ready = 1'b1;
        rx_data  = 8'h00;
        xor_en   = 1'b0;
        tx_busy  = 1'b1;
        ovf_clr  = 1'b0;

        // Reset while busy with rx_ready high.
        tick();
        tick();
        check("rst_tx_send", {31'd0, tx_send}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_level", {27'd0, fifo_level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_heartbeat", {31'd0, heartbeat}, 32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("release_high_no_push", {27'd0, fifo_level}, 32'd0);
        rx_ready = 1'b0;
        tx_busy  = 1'b0;
        repeat (3) tick();
        check("release_no_send", {31'd0, tx_send}, 32'd0);

        // Single echo, with and without the case-toggle mask.
        for (int xe = 1; xe >= 0; xe--) begin
            rx_data  = 8'h61;
            xor_en   = xe[0];
            rx_ready = 1'b1;
            tick();
            check("echo_level_n1", {27'd0, fifo_level}, 32'd1);
            check("echo_nosend_n1", {31'd0, tx_send}, 32'd0);
            rx_ready = 1'b0;
            tick();
            check("echo_send_n2", {31'd0, tx_send}, 32'd1);
            check("echo_data_n2", {24'd0, tx_data}, xe ? 32'h41 : 32'h61);
            check("echo_level_n2", {27'd0, fifo_level}, 32'd0);
            tick();
            check("echo_req_hold", {31'd0, tx_send}, 32'd1);
            tx_busy = 1'b1;
            tick();
            check("echo_send_drop", {31'd0, tx_send}, 32'd0);
            tick();
            tx_busy = 1'b0;
            repeat (2) tick();
        end

        // Heartbeat with CLKFREQ=10: toggles on every 10th edge after reset.
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            tick();
            check("heartbeat", {31'd0, heartbeat}, ((k / 10) % 2));
        end

        // Burst ordering, overflow set/clear precedence.
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0, 1'b0);
        check("burst_level_full", {27'd0, fifo_level}, 32'd16);
        check("burst_no_ovf", {31'd0, overflow}, 32'd0);
        push(8'h10, 1'b0, 1'b0);
        check("drop_sets_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
        check("drop_level", {27'd0, fifo_level}, 32'd16);
        push(8'h11, 1'b0, 1'b1);
        check("set_beats_clr", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 32'd0);
        tx_busy = 1'b0;
        drain(DEPTH);
        repeat (3) tick();
        check("burst_level_empty", {27'd0, fifo_level}, 32'd0);
`ifdef UART_ECHO_FIFO_STATS_EN
        // 16 accepted + 2 dropped edges since the last reset; 16 bytes sent.
        check("rx_count", {16'd0, rx_count}, 32'd18);
        check("tx_count", {16'd0, tx_count}, 32'd16);
`endif

        // Full FIFO: pop and push land in the same cycle.
        tx_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'($urandom), 1'($urandom), 1'b0);
        check("fill_level", {27'd0, fifo_level}, 32'd16);
        begin
            logic [7:0] nb;
            bit         nx;
            nb       = 8'($urandom);
            nx       = 1'($urandom);
            rx_data  = nb;
            xor_en   = nx;
            rx_ready = 1'b1;
            tx_busy  = 1'b0;
            tick();
            rx_ready = 1'b0;
            exp_q.push_back(nb ^ (nx ? MASK : 8'h00));
        end
        check("simul_level", {27'd0, fifo_level}, 32'd16);
        check("simul_no_ovf", {31'd0, overflow}, 32'd0);
        check("simul_send", {31'd0, tx_send}, 32'd1);
        drain(DEPTH + 1);
        repeat (3) tick();
        check("simul_empty", {27'd0, fifo_level}, 32'd0);

        // Randomized rounds of partial fills and drains.
        for (int r = 0; r < 6; r++) begin
            int k;
            k = $urandom_range(1, DEPTH);
            tx_busy = 1'b1;
            for (int i = 0; i < k; i++) push(8'($urandom), 1'($urandom), 1'b0);
            check("rand_level", {27'd0, fifo_level}, k);
            tx_busy = 1'b0;
            drain(k);
            repeat (3) tick();
            check("rand_empty", {27'd0, fifo_level}, 32'd0);
        end

        // Mid-operation reset discards buffered bytes and drops tx_send at once.
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(8'($urandom), 1'b0, 1'b0);
        tx_busy = 1'b0;
        tick();
        check("midrst_pre_send", {31'd0, tx_send}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_send_async", {31'd0, tx_send}, 32'd0);
        check("midrst_level_async", {27'd0, fifo_level}, 32'd0);
        check("midrst_data_async", {24'd0, tx_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (5) tick();
        check("midrst_no_resend", {31'd0, tx_send}, 32'd0);
        check("midrst_level", {27'd0, fifo_level}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
